// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: accepts one load/store from the MEM stage,
// checks alignment and range, drives the word-organised memory port and
// returns an extended load result as a one-cycle response.
module dm_access_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;

  logic        accept;
  logic        req_bad;
  logic [3:0]  be_lat;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic        access_last;

  assign accept      = req_valid && req_ready;
  assign access_last = (state == ACCESS) && (cnt_q == 4'd0);

  // Request legality: size, natural alignment and 4 KB window around ADDR_BASE
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11)                            req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0])             req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  req_bad = 1'b1;
    if (req_addr[31:12] != ADDR_BASE[31:12])          req_bad = 1'b1;
  end

  // Byte-enable pattern for the latched request
  always_comb begin
    be_lat = 4'b0000;
    case (size_q)
      2'b00:   be_lat = 4'b0001 << addr_q[1:0];
      2'b01:   be_lat = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_lat = 4'b1111;
    endcase
  end

  // Lane extraction and sign/zero extension of the memory read word
  always_comb begin
    byte_sel = dm_rd[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = dm_rd[7:0];
      2'b01: byte_sel = dm_rd[15:8];
      2'b10: byte_sel = dm_rd[23:16];
      2'b11: byte_sel = dm_rd[31:24];
      default: byte_sel = dm_rd[7:0];
    endcase
    half_sel = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    ld_data  = dm_rd;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = dm_rd;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_bad ? RESP : ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and memory strobes; all gated by rst so nothing escapes during reset
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == RESP) && !rst;
    dm_we      = access_last && we_q && !rst;
    dm_be      = ((state == ACCESS) && !rst) ? be_lat : 4'b0000;
    dm_addr    = addr_q[11:2];
    dm_wd      = wdata_q;
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[11:0];
        wdata_q <= req_wdata;
        cnt_q   <= WAIT_INIT;
        if (req_bad) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
      end
      if (state == ACCESS) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? 32'h0 : ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a zero-wait instance backed by a small
// lane-steering memory and a three-wait instance with a cycle-varying read word.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rd3_val = '0;

  logic        rdy0, vld0, err0, we0;
  logic [31:0] rdata0, wd0, rd0;
  logic [9:0]  addr0;
  logic [3:0]  be0;
  logic        rdy3, vld3, err3, we3;
  logic [31:0] rdata3, wd3;
  logic [9:0]  addr3;
  logic [3:0]  be3;

  logic [31:0] mem [16];
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  // Observations filled by issue()
  logic        rdy_seen, rdy_after, err, vld_after;
  logic [31:0] rdata, wd1;
  logic [9:0]  addr1;
  logic [3:0]  be1;
  int          we_cnt, we_cyc, rdy_low, resp_cyc;
  int unsigned acc_cyc;

  always #5 clk = ~clk;

  // Free-running cycle stamp
  always @(posedge clk) cyc <= cyc + 1;

  dm_access_ctrl #(.ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld0),
    .resp_rdata(rdata0), .resp_err(err0), .dm_addr(addr0), .dm_be(be0),
    .dm_wd(wd0), .dm_we(we0), .dm_rd(rd0)
  );

  dm_access_ctrl #(.ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld3),
    .resp_rdata(rdata3), .resp_err(err3), .dm_addr(addr3), .dm_be(be3),
    .dm_wd(wd3), .dm_we(we3), .dm_rd(rd3_val)
  );

  // Memory: right-justified write data steered to the enabled lanes
  assign rd0 = mem[addr0[3:0]];
  always @(posedge clk) begin
    if (we0) begin
      case (be0)
        4'hF: mem[addr0[3:0]]        <= wd0;
        4'h3: mem[addr0[3:0]][15:0]  <= wd0[15:0];
        4'hC: mem[addr0[3:0]][31:16] <= wd0[15:0];
        4'h1: mem[addr0[3:0]][7:0]   <= wd0[7:0];
        4'h2: mem[addr0[3:0]][15:8]  <= wd0[7:0];
        4'h4: mem[addr0[3:0]][23:16] <= wd0[7:0];
        4'h8: mem[addr0[3:0]][31:24] <= wd0[7:0];
        default: ;
      endcase
    end
  end

  wire        o_ready = sel ? rdy3 : rdy0;
  wire        o_valid = sel ? vld3 : vld0;
  wire        o_err   = sel ? err3 : err0;
  wire        o_we    = sel ? we3 : we0;
  wire [31:0] o_rdata = sel ? rdata3 : rdata0;
  wire [31:0] o_wd    = sel ? wd3 : wd0;
  wire [9:0]  o_addr  = sel ? addr3 : addr0;
  wire [3:0]  o_be    = sel ? be3 : be0;

  // Drive one request from a negedge, observe until the response, end on the following IDLE negedge
  task automatic issue(input logic s, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    sel = s; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    rd3_val = 32'h1111_0000;
    req_valid = 1'b1;
    rdy_seen = o_ready;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    we_cnt = 0; we_cyc = 0; rdy_low = 0; resp_cyc = 0;
    be1 = o_be; addr1 = o_addr; wd1 = o_wd; err = 1'bx; rdata = 'x;
    for (int c = 1; c <= 20; c++) begin
      rd3_val = 32'h1111_0000 + 32'(c);
      if (o_we) begin we_cnt++; we_cyc = c; end
      if (!o_ready) rdy_low++;
      if (o_valid) begin resp_cyc = c; err = o_err; rdata = o_rdata; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rdy_after = o_ready;
    vld_after = o_valid;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++; if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b%b exp 00", rdy0, rdy3); end
    nvec++; if ({vld0, err0, we0, vld3, err3, we3} !== 6'b0) begin nerr++; $display("FAIL reset_flags got %b exp 000000", {vld0, err0, we0, vld3, err3, we3}); end
    nvec++; if ({rdata0, wd0, addr0, be0} !== 78'b0) begin nerr++; $display("FAIL reset_data got %h exp 0", {rdata0, wd0, addr0, be0}); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin nerr++; $display("FAIL reset_release_ready got %b%b exp 11", rdy0, rdy3); end
  endtask

  task automatic test_store_word;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
    nvec++; if (rdy_seen !== 1'b1) begin nerr++; $display("FAIL sw_ready got %b exp 1", rdy_seen); end
    nvec++; if (addr1 !== 10'd4) begin nerr++; $display("FAIL sw_addr got %0d exp 4", addr1); end
    nvec++; if (be1 !== 4'b1111) begin nerr++; $display("FAIL sw_be got %b exp 1111", be1); end
    nvec++; if (wd1 !== 32'hDEADBEEF) begin nerr++; $display("FAIL sw_wd got %h exp deadbeef", wd1); end
    nvec++; if (we_cnt !== 1 || we_cyc !== 1) begin nerr++; $display("FAIL sw_we got cnt %0d cyc %0d exp 1 1", we_cnt, we_cyc); end
    nvec++; if (resp_cyc !== 2) begin nerr++; $display("FAIL sw_latency got %0d exp 2", resp_cyc); end
    nvec++; if (err !== 1'b0 || rdata !== 32'h0) begin nerr++; $display("FAIL sw_resp got err %b rdata %h exp 0 0", err, rdata); end
    nvec++; if (rdy_after !== 1'b1 || vld_after !== 1'b0) begin nerr++; $display("FAIL sw_after got rdy %b vld %b exp 1 0", rdy_after, vld_after); end
  endtask

  task automatic test_byte;
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h013, 32'h000000A5);
    nvec++; if (be1 !== 4'b1000) begin nerr++; $display("FAIL sb_be got %b exp 1000", be1); end
    nvec++; if (wd1[7:0] !== 8'hA5) begin nerr++; $display("FAIL sb_wd got %h exp a5", wd1[7:0]); end
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
    nvec++; if (rdata !== 32'hFFFFFFA5) begin nerr++; $display("FAIL lb_013 got %h exp ffffffa5", rdata); end
    nvec++; if (we_cnt !== 0 || be1 !== 4'b1000) begin nerr++; $display("FAIL lb_strobes got we %0d be %b exp 0 1000", we_cnt, be1); end
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h013, 32'h0);
    nvec++; if (rdata !== 32'h000000A5) begin nerr++; $display("FAIL lbu_013 got %h exp 000000a5", rdata); end
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h011, 32'h0);
    nvec++; if (rdata !== 32'hFFFFFFBE) begin nerr++; $display("FAIL lb_011 got %h exp ffffffbe", rdata); end
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h010, 32'h0);
    nvec++; if (rdata !== 32'h000000EF) begin nerr++; $display("FAIL lbu_010 got %h exp 000000ef", rdata); end
  endtask

  task automatic test_half;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h012, 32'h00008001);
    nvec++; if (be1 !== 4'b1100) begin nerr++; $display("FAIL sh_be got %b exp 1100", be1); end
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h012, 32'h0);
    nvec++; if (rdata !== 32'hFFFF8001) begin nerr++; $display("FAIL lh_012 got %h exp ffff8001", rdata); end
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h012, 32'h0);
    nvec++; if (rdata !== 32'h00008001) begin nerr++; $display("FAIL lhu_012 got %h exp 00008001", rdata); end
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h010, 32'h0);
    nvec++; if (rdata !== 32'hFFFFBEEF || be1 !== 4'b0011) begin nerr++; $display("FAIL lh_010 got %h be %b exp ffffbeef 0011", rdata, be1); end
    issue(1'b0, 1'b0, 2'b10, 1'b1, 32'h010, 32'h0);
    nvec++; if (rdata !== 32'h8001BEEF) begin nerr++; $display("FAIL lw_010 got %h exp 8001beef", rdata); end
  endtask

  task automatic test_errors;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h006, 32'h0);
    nvec++; if (err !== 1'b1 || rdata !== 32'h0) begin nerr++; $display("FAIL lw_misalign got err %b rdata %h exp 1 0", err, rdata); end
    nvec++; if (resp_cyc !== 1 || we_cnt !== 0 || be1 !== 4'b0) begin nerr++; $display("FAIL lw_misalign_path got resp %0d we %0d be %b exp 1 0 0000", resp_cyc, we_cnt, be1); end
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678);
    nvec++; if (err !== 1'b1 || resp_cyc !== 1 || we_cnt !== 0) begin nerr++; $display("FAIL sw_range got err %b resp %0d we %0d exp 1 1 0", err, resp_cyc, we_cnt); end
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h011, 32'h0000FFFF);
    nvec++; if (err !== 1'b1 || we_cnt !== 0) begin nerr++; $display("FAIL sh_odd got err %b we %0d exp 1 0", err, we_cnt); end
    issue(1'b0, 1'b0, 2'b11, 1'b0, 32'h010, 32'h0);
    nvec++; if (err !== 1'b1 || resp_cyc !== 1) begin nerr++; $display("FAIL size11 got err %b resp %0d exp 1 1", err, resp_cyc); end
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    nvec++; if (err !== 1'b0 || rdata !== 32'h8001BEEF) begin nerr++; $display("FAIL after_err got err %b rdata %h exp 0 8001beef", err, rdata); end
  endtask

  task automatic test_back_to_back;
    int unsigned first;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    first = acc_cyc;
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h012, 32'h0);
    nvec++; if (acc_cyc - first !== 3 || rdy_seen !== 1'b1) begin nerr++; $display("FAIL b2b_w0 got gap %0d rdy %b exp 3 1", acc_cyc - first, rdy_seen); end
    nvec++; if (rdata !== 32'h00000001) begin nerr++; $display("FAIL b2b_w0_data got %h exp 00000001", rdata); end
  endtask

  task automatic test_wait3;
    int unsigned first;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    first = acc_cyc;
    nvec++; if (rdy_low !== 5) begin nerr++; $display("FAIL w3_ready_low got %0d exp 5", rdy_low); end
    nvec++; if (resp_cyc !== 5) begin nerr++; $display("FAIL w3_latency got %0d exp 5", resp_cyc); end
    nvec++; if (rdata !== 32'h11110004 || err !== 1'b0) begin nerr++; $display("FAIL w3_capture got %h err %b exp 11110004 0", rdata, err); end
    nvec++; if (addr1 !== 10'd4 || be1 !== 4'b1111) begin nerr++; $display("FAIL w3_port got addr %0d be %b exp 4 1111", addr1, be1); end
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h021, 32'h0000007E);
    nvec++; if (acc_cyc - first !== 6) begin nerr++; $display("FAIL w3_gap got %0d exp 6", acc_cyc - first); end
    nvec++; if (we_cnt !== 1 || we_cyc !== 4 || be1 !== 4'b0010) begin nerr++; $display("FAIL w3_store got we %0d cyc %0d be %b exp 1 4 0010", we_cnt, we_cyc, be1); end
  endtask

  task automatic test_reset_midop;
    int bad_we, bad_vld;
    logic r3, r4;
    bad_we = 0; bad_vld = 0; r3 = 1'bx; r4 = 1'bx;
    sel = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h010; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (we3) bad_we++;
      if (vld3) bad_vld++;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin r3 = rdy3; rst = 1'b0; end
      if (c == 4) r4 = rdy3;
      @(negedge clk);
    end
    nvec++; if (bad_we !== 0 || bad_vld !== 0) begin nerr++; $display("FAIL midrst_quiet got we %0d vld %0d exp 0 0", bad_we, bad_vld); end
    nvec++; if (r3 !== 1'b0 || r4 !== 1'b1) begin nerr++; $display("FAIL midrst_ready got %b%b exp 01", r3, r4); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset;
    test_store_word;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_wait3;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
